// File: rtl/Types.sv
// Shared RISC-V datapath types.
// Holds the branch-comparison and opcode encodings used elsewhere in the core,
// plus the load/store size encoding (funct3) consumed by the memory responder.
// No ports: type/constant package only.
package Types;

  // Branch comparison selector (funct3 of BRANCH instructions).
  typedef enum logic [2:0] {
    CMP_EQ  = 3'b000,
    CMP_NE  = 3'b001,
    CMP_LT  = 3'b100,
    CMP_GE  = 3'b101,
    CMP_LTU = 3'b110,
    CMP_GEU = 3'b111
  } cmp_op_t;

  // Major opcodes the core decodes.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_STORE  = 7'b0100011,
    OP_REG    = 7'b0110011,
    OP_BRANCH = 7'b1100011
  } opcode_t;

  // Load/store access size and sign (funct3 of LOAD/STORE).
  typedef enum logic [2:0] {
    SIZE_B  = 3'b000,
    SIZE_H  = 3'b001,
    SIZE_W  = 3'b010,
    SIZE_BU = 3'b100,
    SIZE_HU = 3'b101
  } mem_size_t;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsu_align.sv
// Load/store lane alignment for a 32-bit word memory.
// Ports:
//   size        in  funct3 size code (mem_size_t encoding, raw bits)
//   offset      in  byte offset within the word (addr[1:0])
//   store_data  in  right-aligned store data
//   mem_word    in  current contents of the addressed word
//   load_data   out selected lane, sign/zero extended (W: word unchanged)
//   store_word  out store data replicated onto the addressed lanes
//   byte_en     out per-byte write enables for the addressed lanes
//   bad_access  out misaligned access or unlisted size code
module lsu_align
  import Types::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_word,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_en,
  output logic        bad_access
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = mem_word[8*offset +: 8];
    lane_h     = offset[1] ? mem_word[31:16] : mem_word[15:0];
    load_data  = '0;
    store_word = '0;
    byte_en    = '0;
    bad_access = 1'b0;
    case (mem_size_t'(size))
      SIZE_B, SIZE_BU: begin
        load_data  = (size == SIZE_B) ? {{24{lane_b[7]}}, lane_b} : {24'd0, lane_b};
        // Replicating the byte lets the enables alone pick the lane.
        store_word = {4{store_data[7:0]}};
        byte_en    = 4'b0001 << offset;
      end
      SIZE_H, SIZE_HU: begin
        load_data  = (size == SIZE_H) ? {{16{lane_h[15]}}, lane_h} : {16'd0, lane_h};
        store_word = {2{store_data[15:0]}};
        byte_en    = offset[1] ? 4'b1100 : 4'b0011;
        bad_access = offset[0];
      end
      SIZE_W: begin
        load_data  = mem_word;
        store_word = store_data;
        byte_en    = 4'b1111;
        bad_access = (offset != 2'b00);
      end
      default: bad_access = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Wait-stated word memory answering CPU load/store/fetch requests.
// A request is latched in IDLE, optionally waits WAIT_STATES cycles, then the
// access is performed on the edge entering DONE, which lasts one cycle.
// Ports:
//   clk    in  sole clock, rising edge
//   rst    in  asynchronous active-high reset
//   req    in  access request, held until completion (dropping it in WAIT aborts)
//   addr   in  byte address
//   we     in  1 = store, 0 = load/fetch
//   size   in  funct3 size/sign code
//   wdata  in  right-aligned store data
//   rdata  out aligned/extended load data, valid with done, held otherwise
//   stall  out req && not in DONE
//   done   out one-cycle completion pulse
//   err    out fault pulse coincident with done
module mem_responder
  import Types::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam int CNT_W = 4;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      addr_reg, wdata_reg, rdata_reg;
  logic             we_reg;
  logic [2:0]       size_reg;

  logic             accept;
  logic [31:0]      eff_addr, eff_wdata;
  logic             eff_we;
  logic [2:0]       eff_size;
  logic             out_of_range, bad_access, fault;
  logic             enter_done, mem_wr;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_word, load_data, store_word;
  logic [3:0]       byte_en;

  logic [31:0]      mem [DEPTH_WORDS];

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_STATES > 0) begin
            state_next = WAIT;
            cnt_next   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_next = DONE;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, before the
  // request registers hold it; the live inputs are used then (same values).
  assign eff_addr  = accept ? addr  : addr_reg;
  assign eff_wdata = accept ? wdata : wdata_reg;
  assign eff_we    = accept ? we    : we_reg;
  assign eff_size  = accept ? size  : size_reg;

  assign out_of_range = ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign fault        = out_of_range | bad_access;
  assign mem_idx      = eff_addr[IDX_W+1:2];
  assign mem_word     = mem[mem_idx];

  // The storage array has no reset, so writes must be blocked while rst is high.
  assign enter_done = (state_next == DONE) && (state_reg != DONE) && !rst;
  assign mem_wr     = enter_done && eff_we && !fault;

  lsu_align u_align (
    .size       (eff_size),
    .offset     (eff_addr[1:0]),
    .store_data (eff_wdata),
    .mem_word   (mem_word),
    .load_data  (load_data),
    .store_word (store_word),
    .byte_en    (byte_en),
    .bad_access (bad_access)
  );

  // State register and request/response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      size_reg  <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= addr;
        wdata_reg <= wdata;
        we_reg    <= we;
        size_reg  <= size;
      end
      if (enter_done) begin
        rdata_reg <= fault ? 32'd0 : load_data;
      end
    end
  end

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (byte_en[i]) begin
          mem[mem_idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    stall = req && (state_reg != DONE);
    done  = (state_reg == DONE);
    err   = (state_reg == DONE) && fault;
  end

  assign rdata = rdata_reg;

endmodule
